mp_fetch_unit: RTL and testbench

- Instruction fetch/issue stage directly upstream of mp_top; drives mp_top's 32-bit instruction input.
- Holds a host-loaded program in a local instruction memory and walks it with a program counter.
- Issues only legal-opcode instructions under a valid/ready handshake, skips illegal ones, and reports completion and counts.

---
 rtl/mp_pkg.sv | 27 ++
 rtl/mp_fetch_if.sv | 8 +
 rtl/mp_instr_mem.sv | 20 ++
 rtl/mp_fetch_unit.sv | 99 +++++++++
 tb/tb_mp_fetch_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mp_pkg.sv
// mp_pkg: opcodes, instruction field positions, legality check and fetch FSM states
package mp_pkg;
    localparam logic [5:0] OP_ADD = 6'h04;
    localparam logic [5:0] OP_SUB = 6'h0E;
    localparam logic [5:0] OP_ABS = 6'h08;
    localparam logic [5:0] OP_NEG = 6'h0B;
    localparam logic [5:0] OP_MAX = 6'h0A;
    localparam logic [5:0] OP_MIN = 6'h01;
    localparam logic [5:0] OP_AVG = 6'h0D;
    localparam logic [5:0] OP_NOT = 6'h06;
    localparam logic [5:0] OP_OR  = 6'h09;
    localparam logic [5:0] OP_AND = 6'h05;
    localparam logic [5:0] OP_XOR = 6'h07;
    localparam int OP_LSB = 0;
    localparam int OP_MSB = 5;
    localparam int A1_LSB = 6;
    localparam int A1_MSB = 10;
    localparam int A2_LSB = 11;
    localparam int A2_MSB = 15;
    localparam int A3_LSB = 16;
    localparam int A3_MSB = 20;
    typedef enum logic [2:0] {IDLE, FETCH, EVAL, ISSUE, DONE} state_t;
    function automatic logic is_legal_opcode(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_ABS, OP_NEG, OP_MAX, OP_MIN,
                          OP_AVG, OP_NOT, OP_OR, OP_AND, OP_XOR};
    endfunction
endpackage

// File: rtl/mp_fetch_if.sv
// mp_fetch_if: valid/ready instruction handshake between fetch unit and mp_top
interface mp_fetch_if;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        mp_ready;
    modport master (output instruction, output instr_valid, input mp_ready);
    modport slave  (input instruction, input instr_valid, output mp_ready);
endinterface

// File: rtl/mp_instr_mem.sv
// mp_instr_mem: DEPTH x 32 instruction store, synchronous write, registered read
module mp_instr_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    // write port and read register; contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/mp_fetch_unit.sv
// mp_fetch_unit: walks a loaded program and issues legal-opcode words to mp_top
module mp_fetch_unit
    import mp_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    mp_fetch_if.master    bus,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [CW-1:0] issued_count,
    output logic [CW-1:0] skipped_count
);
    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [CW-1:0] iss_q, iss_d, skp_q, skp_d;
    logic [31:0]   instr_q;
    logic          last, legal;

    mp_instr_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .we_i    (load_en && state_q == IDLE),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .re_i    (state_q == FETCH),
        .raddr_i (pc_q),
        .rdata_o (instr_q)
    );

    assign last  = {1'b0, pc_q} == len_q - 1'b1;
    assign legal = is_legal_opcode(instr_q[OP_MSB:OP_LSB]);

    assign bus.instr_valid = state_q == ISSUE;
    assign bus.instruction = state_q == ISSUE ? instr_q : 32'h0;
    assign busy            = state_q inside {FETCH, EVAL, ISSUE};
    assign done            = state_q == DONE;
    assign pc              = pc_q;
    assign issued_count    = iss_q;
    assign skipped_count   = skp_q;

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            iss_q   <= '0;
            skp_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            iss_q   <= iss_d;
            skp_q   <= skp_d;
        end
    end

    // next state: start/load arbitration, skip or issue, advance pc until last word
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        iss_d   = iss_q;
        skp_d   = skp_q;
        case (state_q)
            IDLE: if (start && !load_en) begin
                len_d   = prog_len;
                pc_d    = '0;
                iss_d   = '0;
                skp_d   = '0;
                state_d = prog_len == '0 ? DONE : FETCH;
            end
            FETCH: state_d = EVAL;
            EVAL: if (legal) state_d = ISSUE;
            else begin
                skp_d   = skp_q + {{(CW-1){1'b0}}, ~&skp_q};
                state_d = last ? DONE : FETCH;
                pc_d    = last ? pc_q : pc_q + 1'b1;
            end
            ISSUE: if (bus.mp_ready) begin
                iss_d   = iss_q + {{(CW-1){1'b0}}, ~&iss_q};
                state_d = last ? DONE : FETCH;
                pc_d    = last ? pc_q : pc_q + 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mp_fetch_unit.sv
// tb_mp_fetch_unit: table-driven single-word programs plus multi-cycle corner sequences
module tb_mp_fetch_unit;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int CW    = 16;

    typedef struct {
        logic [31:0] word;
        logic        legal;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset, load_en, start;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [AW:0]   prog_len;
    logic          busy, done;
    logic [AW-1:0] pc;
    logic [CW-1:0] issued_count, skipped_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] issues[$];
    int first_valid, ill_seen, done_cyc;
    logic [AW-1:0] done_pc;
    logic [5:0] ops[11] = '{6'h04, 6'h0E, 6'h08, 6'h0B, 6'h0A, 6'h01, 6'h0D, 6'h06, 6'h09, 6'h05, 6'h07};
    vec_t vecs[15];

    mp_fetch_if bus();

    mp_fetch_unit #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .prog_len      (prog_len),
        .start         (start),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .pc            (pc),
        .issued_count  (issued_count),
        .skipped_count (skipped_count)
    );

    always #5 clk = ~clk;

    function automatic logic legal_op(input logic [5:0] op);
        for (int i = 0; i < 11; i++) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic start_prog(input int len);
        prog_len = (AW+1)'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // observe from the cycle after start until the done pulse, logging handshakes
    task automatic run(input int budget);
        int cyc;
        cyc = 0;
        issues.delete();
        first_valid = -1;
        ill_seen = 0;
        done_cyc = -1;
        while (cyc < budget) begin
            if (bus.instr_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (!legal_op(bus.instruction[5:0])) ill_seen++;
                if (bus.mp_ready) issues.push_back(bus.instruction);
            end
            if (done) begin
                done_cyc = cyc;
                done_pc = pc;
                break;
            end
            tick();
            cyc++;
        end
        chk("run_done_within_budget", 64'(done_cyc >= 0), 64'd1);
        tick();
    endtask

    initial begin
        vecs[0]  = '{32'h001F1044, 1'b1};
        vecs[1]  = '{32'h0000084E, 1'b1};
        vecs[2]  = '{32'h00011048, 1'b1};
        vecs[3]  = '{32'h001FFFCB, 1'b1};
        vecs[4]  = '{32'h0000004A, 1'b1};
        vecs[5]  = '{32'h00020801, 1'b1};
        vecs[6]  = '{32'h0003104D, 1'b1};
        vecs[7]  = '{32'h00000006, 1'b1};
        vecs[8]  = '{32'hFFE00009, 1'b1};
        vecs[9]  = '{32'h0010FFC5, 1'b1};
        vecs[10] = '{32'h00042047, 1'b1};
        vecs[11] = '{32'h0000003F, 1'b0};
        vecs[12] = '{32'h00000000, 1'b0};
        vecs[13] = '{32'h00FFFFC3, 1'b0};
        vecs[14] = '{32'h00000010, 1'b0};

        reset = 1'b1; load_en = 1'b0; start = 1'b0; load_addr = '0;
        load_data = '0; prog_len = '0; bus.mp_ready = 1'b1;
        tick(); tick();
        chk("reset_valid", 64'(bus.instr_valid), 64'd0);
        chk("reset_instr", 64'(bus.instruction), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_pc", 64'(pc), 64'd0);
        chk("reset_issued", 64'(issued_count), 64'd0);
        chk("reset_skipped", 64'(skipped_count), 64'd0);
        reset = 1'b0;
        tick();

        // single-word programs: legal words issue once (valid 2 cycles after FETCH), illegal skip
        for (int v = 0; v < 15; v++) begin
            load(0, vecs[v].word);
            start_prog(1);
            chk("vec_busy_after_start", 64'(busy), 64'd1);
            run(20);
            chk("vec_issued", 64'(issued_count), 64'(vecs[v].legal));
            chk("vec_skipped", 64'(skipped_count), 64'(!vecs[v].legal));
            chk("vec_n_issues", 64'(issues.size()), 64'(vecs[v].legal));
            chk("vec_done_cycle", 64'(done_cyc), vecs[v].legal ? 64'd3 : 64'd2);
            chk("vec_illegal_valid", 64'(ill_seen), 64'd0);
            if (vecs[v].legal) begin
                chk("vec_first_valid", 64'(first_valid), 64'd2);
                chk("vec_word", 64'(issues[0]), 64'(vecs[v].word));
            end
            chk("vec_done_one_cycle", 64'(done), 64'd0);
        end

        // skip an illegal word between two legal ones
        load(0, 32'h001F1044);
        load(1, 32'h0000003F);
        load(2, 32'h0010FFC5);
        start_prog(3);
        run(40);
        chk("skip_n_issues", 64'(issues.size()), 64'd2);
        chk("skip_issue0", 64'(issues[0]), 64'h001F1044);
        chk("skip_issue1", 64'(issues[1]), 64'h0010FFC5);
        chk("skip_issued", 64'(issued_count), 64'd2);
        chk("skip_skipped", 64'(skipped_count), 64'd1);
        chk("skip_no_illegal_valid", 64'(ill_seen), 64'd0);
        chk("skip_done_pc", 64'(done_pc), 64'd2);

        // backpressure: six cycles of stable valid, handshake on the sixth
        load(0, 32'h001F1044);
        bus.mp_ready = 1'b0;
        start_prog(1);
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", 64'(bus.instr_valid), 64'd1);
            chk("bp_instr", 64'(bus.instruction), 64'h001F1044);
            chk("bp_no_done", 64'(done), 64'd0);
            if (i == 5) bus.mp_ready = 1'b1;
            tick();
        end
        chk("bp_done", 64'(done), 64'd1);
        chk("bp_valid_off", 64'(bus.instr_valid), 64'd0);
        chk("bp_issued", 64'(issued_count), 64'd1);
        tick();
        chk("bp_done_pulse", 64'(done), 64'd0);
        chk("bp_idle", 64'(busy), 64'd0);

        // zero-length program
        start_prog(0);
        run(10);
        chk("len0_done_cycle", 64'(done_cyc), 64'd0);
        chk("len0_no_valid", 64'(first_valid), 64'hFFFFFFFFFFFFFFFF);
        chk("len0_issued", 64'(issued_count), 64'd0);

        // full-depth program
        for (int i = 0; i < DEPTH; i++) load(i, {8'(i), 18'h0, ops[i % 11]});
        start_prog(DEPTH);
        run(400);
        chk("full_n_issues", 64'(issues.size()), 64'd32);
        chk("full_issued", 64'(issued_count), 64'd32);
        chk("full_pc", 64'(done_pc), 64'd31);
        chk("full_last", 64'(issues[31]), 64'h1F000005);
        chk("full_first", 64'(issues[0]), 64'h00000004);

        // load and start while busy are ignored
        start_prog(3);
        load_en = 1'b1; load_addr = '0; load_data = '0; start = 1'b1; prog_len = 6'd1;
        tick();
        load_en = 1'b0; start = 1'b0;
        run(40);
        chk("ign_n_issues", 64'(issues.size()), 64'd3);
        chk("ign_issued", 64'(issued_count), 64'd3);
        start_prog(1);
        run(20);
        chk("ign_mem_kept", 64'(issues[0]), 64'h00000004);

        // reset during ISSUE of the second word
        start_prog(3);
        tick(); tick(); tick();
        bus.mp_ready = 1'b0;
        tick(); tick();
        chk("rst_pre_valid", 64'(bus.instr_valid), 64'd1);
        chk("rst_pre_instr", 64'(bus.instruction), 64'h01000004 | 64'h0E);
        chk("rst_pre_issued", 64'(issued_count), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_instr", 64'(bus.instruction), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_issued", 64'(issued_count), 64'd0);
        chk("rst_skipped", 64'(skipped_count), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        bus.mp_ready = 1'b1;
        start_prog(1);
        run(20);
        chk("rst_mem_kept", 64'(issues[0]), 64'h00000004);
        chk("rst_reissue_count", 64'(issued_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
